// File: rtl/cmac_xmit_generator.sv
// Synthetic CMAC axis_tx packet source: one header beat followed by 1, 2 or 64 payload beats.
// Optional TVALID-drop error injection is built when CMAC_XMIT_GEN_ERRINJ_EN is defined.
module cmac_xmit_generator #(
  parameter int DW = 512
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic          stop,
  input  logic [31:0]   packet_count,
  input  logic [1:0]    size_mode,
  input  logic [7:0]    gap_cycles,
  input  logic          inject_drop,
  output logic [DW-1:0] axis_out_tdata,
  output logic          axis_out_tlast,
  output logic          axis_out_tvalid,
  input  logic          axis_out_tready,
  output logic          busy,
  output logic          done,
  output logic [31:0]   packets_sent
);

  typedef enum logic [1:0] {IDLE, HEADER, PAYLOAD, GAP} state_t;

  state_t      state;
  logic [31:0] count_q;
  logic [31:0] seq;
  logic [1:0]  mode_q;
  logic [7:0]  gap_q;
  logic [7:0]  gap_cnt;
  logic [1:0]  rot;
  logic [15:0] n_cur;
  logic [15:0] k;
  logic [1:0]  rot_next;
  logic [15:0] n_next;
  logic        hs;
  logic        run_end;

`ifdef CMAC_XMIT_GEN_ERRINJ_EN
  logic armed;
`else
  logic unused_inject;
  assign unused_inject = inject_drop;
`endif

  function automatic logic [15:0] size_of(input logic [1:0] mode, input logic [1:0] r);
    logic [15:0] n;
    n = 16'd64;
    case (mode)
      2'd0: n = 16'd1;
      2'd1: n = 16'd2;
      2'd2: n = 16'd64;
      default: begin
        case (r)
          2'd0:    n = 16'd1;
          2'd1:    n = 16'd2;
          default: n = 16'd64;
        endcase
      end
    endcase
    return n;
  endfunction

  function automatic logic [DW-1:0] beat(input logic [31:0] s, input logic [15:0] v);
    logic [DW-1:0] b;
    b = '0;
    b[31:0]  = s;
    b[47:32] = v;
    return b;
  endfunction

  assign hs = axis_out_tvalid & axis_out_tready;

  // Rotation and size of the packet that follows the current one.
  always_comb begin
    rot_next = rot;
    if (mode_q == 2'd3) rot_next = (rot == 2'd2) ? 2'd0 : rot + 2'd1;
    n_next  = size_of(mode_q, rot_next);
    run_end = ((count_q != '0) && (packets_sent + 32'd1 == count_q)) || stop;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state           <= IDLE;
      count_q         <= '0;
      seq             <= '0;
      mode_q          <= '0;
      gap_q           <= '0;
      gap_cnt         <= '0;
      rot             <= '0;
      n_cur           <= '0;
      k               <= '0;
      axis_out_tdata  <= '0;
      axis_out_tlast  <= 1'b0;
      axis_out_tvalid <= 1'b0;
      busy            <= 1'b0;
      done            <= 1'b0;
      packets_sent    <= '0;
`ifdef CMAC_XMIT_GEN_ERRINJ_EN
      armed           <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            count_q         <= packet_count;
            mode_q          <= size_mode;
            gap_q           <= gap_cycles;
            packets_sent    <= '0;
            seq             <= '0;
            rot             <= '0;
            n_cur           <= size_of(size_mode, 2'd0);
            axis_out_tdata  <= beat(32'd0, size_of(size_mode, 2'd0));
            axis_out_tvalid <= 1'b1;
            axis_out_tlast  <= 1'b0;
            busy            <= 1'b1;
            state           <= HEADER;
          end
        end

        HEADER: begin
          if (hs) begin
            k              <= 16'd1;
            axis_out_tdata <= beat(seq, 16'd1);
            axis_out_tlast <= (n_cur == 16'd1);
            state          <= PAYLOAD;
          end
        end

        PAYLOAD: begin
          if (hs && axis_out_tlast) begin
            packets_sent   <= packets_sent + 32'd1;
            seq            <= seq + 32'd1;
            rot            <= rot_next;
            n_cur          <= n_next;
            axis_out_tlast <= 1'b0;
`ifdef CMAC_XMIT_GEN_ERRINJ_EN
            armed          <= 1'b0;
`endif
            if (run_end) begin
              axis_out_tvalid <= 1'b0;
              axis_out_tdata  <= '0;
              busy            <= 1'b0;
              done            <= 1'b1;
              state           <= IDLE;
            end else if (gap_q != '0) begin
              axis_out_tvalid <= 1'b0;
              axis_out_tdata  <= '0;
              gap_cnt         <= gap_q;
              state           <= GAP;
            end else begin
              axis_out_tdata <= beat(seq + 32'd1, n_next);
              state          <= HEADER;
            end
          end else if (hs) begin
            k              <= k + 16'd1;
            axis_out_tdata <= beat(seq, k + 16'd1);
            axis_out_tlast <= (k + 16'd1 == n_cur);
`ifdef CMAC_XMIT_GEN_ERRINJ_EN
            // Next beat is already loaded; TVALID stays low for one cycle.
            if (armed || inject_drop) axis_out_tvalid <= 1'b0;
            armed <= 1'b0;
`endif
          end
`ifdef CMAC_XMIT_GEN_ERRINJ_EN
          else begin
            if (!axis_out_tvalid) axis_out_tvalid <= 1'b1;
            if (inject_drop && !axis_out_tlast) armed <= 1'b1;
          end
`endif
        end

        GAP: begin
          if (stop) begin
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= IDLE;
          end else if (gap_cnt == 8'd1) begin
            axis_out_tvalid <= 1'b1;
            axis_out_tdata  <= beat(seq, n_cur);
            state           <= HEADER;
          end else begin
            gap_cnt <= gap_cnt - 8'd1;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule
